sys_bridge: RTL and testbench

SYS_BRIDGE -- requirements
Module: sys_bridge

---
 rtl/sys_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_sys_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge.sv
// sys_bridge: bridges one CPU request port to a data memory and NSLV peripheral slots.
// Three-state access engine: IDLE -> ACCESS -> RESP.
// Optional interrupt register block is enabled by defining SYS_BRIDGE_IRQ_EN.
module sys_bridge #(
  parameter int unsigned NSLV       = 2,
  parameter logic [31:0] SLV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] SLV_STRIDE = 32'h10,
  parameter logic [31:0] SLV_SPAN   = 32'hc,
  parameter logic [31:0] DM_END     = 32'h0000_2fff,
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [31:0] IRQ_ADDR   = 32'h0000_7f30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wd,
  input  logic [3:0]         cpu_byteen,
  output logic               cpu_ack,
  output logic [31:0]        cpu_rd,
  output logic               cpu_err,
  output logic [31:0]        dm_addr,
  output logic [31:0]        dm_wd,
  output logic [3:0]         dm_we,
  input  logic [31:0]        dm_rd,
  output logic [31:0]        slv_addr,
  output logic [31:0]        slv_wd,
  output logic [NSLV-1:0]    slv_sel,
  output logic               slv_we,
  input  logic [32*NSLV-1:0] slv_rd,
  input  logic [NSLV-1:0]    slv_ready,
  input  logic [NSLV-1:0]    irq_in,
  output logic               irq_out
);
  localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  // TgtErr covers unmapped addresses and illegal partial writes: both end in err=1, rd=0.
  typedef enum logic [1:0] {TgtDm, TgtSlv, TgtIrq, TgtErr} tgt_e;

  state_e            state_q, state_d;
  tgt_e              tgt_q, tgt_d, dec_tgt;
  logic [31:0]       addr_q, addr_d, wd_q, wd_d, rd_q, rd_d;
  logic [3:0]        be_q, be_d;
  logic [IdxW-1:0]   idx_q, idx_d, dec_idx;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d, slot_hit, sel_rdy, partial;
  logic [31:0]       sel_rd;
  logic [NSLV-1:0]   sel_oh;

`ifdef SYS_BRIDGE_IRQ_EN
  logic [NSLV-1:0] pend_q, mask_q, mask_d;
  logic            irq_q;
`else
  logic unused_irq_in;
  assign unused_irq_in = ^irq_in;
`endif

  assign partial = (cpu_byteen != 4'b0000) && (cpu_byteen != 4'b1111);

  // Address decode of the incoming request; first matching slot wins.
  always_comb begin
    dec_tgt  = TgtErr;
    dec_idx  = '0;
    slot_hit = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (!slot_hit && ((cpu_addr - (SLV_BASE + 32'(i) * SLV_STRIDE)) < SLV_SPAN)) begin
        slot_hit = 1'b1;
        dec_idx  = IdxW'(i);
      end
    end
    if (cpu_addr <= DM_END) begin
      dec_tgt = TgtDm;
    end
`ifdef SYS_BRIDGE_IRQ_EN
    else if (cpu_addr == IRQ_ADDR) begin
      dec_tgt = partial ? TgtErr : TgtIrq;
    end
`endif
    else if (slot_hit) begin
      dec_tgt = partial ? TgtErr : TgtSlv;
    end
  end

  // Select read data, ready and one-hot select for the registered slot index.
  always_comb begin
    sel_rd  = '0;
    sel_rdy = 1'b0;
    sel_oh  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (IdxW'(i) == idx_q) begin
        sel_rd    = slv_rd[32*i +: 32];
        sel_rdy   = slv_ready[i];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Next-state logic for the access engine and response registers.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
`ifdef SYS_BRIDGE_IRQ_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wd_d    = cpu_wd;
          be_d    = cpu_byteen;
          tgt_d   = dec_tgt;
          idx_d   = dec_idx;
          cnt_d   = '0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        unique case (tgt_q)
          TgtDm: begin
            rd_d    = dm_rd;
            err_d   = 1'b0;
            state_d = StResp;
          end
          TgtSlv: begin
            if (sel_rdy) begin
              rd_d    = sel_rd;
              err_d   = 1'b0;
              state_d = StResp;
            end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
              rd_d    = '0;
              err_d   = 1'b1;
              state_d = StResp;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
`ifdef SYS_BRIDGE_IRQ_EN
          TgtIrq: begin
            if (be_q == 4'b0000) begin
              rd_d = {16'(pend_q), 16'(mask_q)};
            end else begin
              rd_d   = '0;
              mask_d = wd_q[NSLV-1:0];
            end
            err_d   = 1'b0;
            state_d = StResp;
          end
`endif
          default: begin
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        endcase
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tgt_q   <= TgtDm;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

`ifdef SYS_BRIDGE_IRQ_EN
  // Interrupt pending/mask registers and registered aggregate output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= irq_in;
      mask_q <= mask_d;
      irq_q  <= |(pend_q & mask_q);
    end
  end
  assign irq_out = irq_q;
`else
  assign irq_out = 1'b0;
`endif

  // Strobes are decoded from state so a reset drops them immediately.
  always_comb begin
    cpu_ack  = (state_q == StResp);
    cpu_rd   = rd_q;
    cpu_err  = err_q;
    dm_addr  = addr_q;
    dm_wd    = wd_q;
    slv_addr = addr_q;
    slv_wd   = wd_q;
    dm_we    = (state_q == StAccess && tgt_q == TgtDm) ? be_q : 4'b0000;
    slv_sel  = (state_q == StAccess && tgt_q == TgtSlv) ? sel_oh : '0;
    slv_we   = (state_q == StAccess && tgt_q == TgtSlv && be_q == 4'b1111);
  end

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: transaction-level model plus directed literal checks.
// Works with or without SYS_BRIDGE_IRQ_EN defined.
module tb_sys_bridge;
  localparam int unsigned NSLV = 2;
  localparam int unsigned T    = 15;
  localparam logic [31:0] BASE = 32'h7f00, STRIDE = 32'h10, SPAN = 32'hc;
  localparam logic [31:0] DMEND = 32'h2fff, IRQA = 32'h7f30;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_req;
  logic [31:0]       cpu_addr, cpu_wd, cpu_rd, dm_addr, dm_wd, dm_rd, slv_addr, slv_wd;
  logic [3:0]        cpu_byteen, dm_we;
  logic              cpu_ack, cpu_err, slv_we, irq_out;
  logic [NSLV-1:0]   slv_sel, slv_ready, irq_in;
  logic [32*NSLV-1:0] slv_rd;

  always #5 clk = ~clk;

  sys_bridge #(
    .NSLV(NSLV), .SLV_BASE(BASE), .SLV_STRIDE(STRIDE), .SLV_SPAN(SPAN),
    .DM_END(DMEND), .TIMEOUT(T), .IRQ_ADDR(IRQA)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_byteen(cpu_byteen), .cpu_ack(cpu_ack), .cpu_rd(cpu_rd), .cpu_err(cpu_err),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd),
    .slv_addr(slv_addr), .slv_wd(slv_wd), .slv_sel(slv_sel), .slv_we(slv_we),
    .slv_rd(slv_rd), .slv_ready(slv_ready), .irq_in(irq_in), .irq_out(irq_out)
  );

  typedef struct packed {
    logic            ack;
    logic            acc;
    logic [3:0]      dwe;
    logic [NSLV-1:0] sel;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic            err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_rd = '0;
  logic        m_err = 1'b0;
  logic [NSLV-1:0] m_mask = '0;
  bit          mon_en = 0;
  int          ready_dly = 0;
  int          sel_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Peripheral responder: selected slot raises ready once sel has been held ready_dly cycles.
  always @(negedge clk) begin
    if (|slv_sel) sel_run = sel_run + 1;
    else sel_run = 0;
    slv_ready = (sel_run > ready_dly) ? slv_sel : '0;
  end

  // Transaction model: derives the cycle timeline of one access from the address map rules.
  task automatic predict(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int dly);
    exp_t e;
    int   slot, n;
    logic [31:0] lo;
    e = '0; e.acc = 1'b1; e.addr = a; e.wd = wd; e.err = 1'b1;
    n = 1; slot = -1;
    for (int i = 0; i < NSLV; i++) begin
      lo = BASE + 32'(i) * STRIDE;
      if (slot < 0 && a >= lo && a < lo + SPAN) slot = i;
    end
    if (a <= DMEND) begin
      e.dwe = be; e.rd = dm_rd; e.err = 1'b0;
    end
`ifdef SYS_BRIDGE_IRQ_EN
    else if (a == IRQA) begin
      if (be == 4'h0) begin
        e.rd = {16'(irq_in), 16'(m_mask)}; e.err = 1'b0;
      end else if (be == 4'hf) begin
        m_mask = wd[NSLV-1:0]; e.err = 1'b0;
      end
    end
`endif
    else if (slot >= 0 && (be == 4'h0 || be == 4'hf)) begin
      e.sel = NSLV'(1 << slot);
      e.we  = (be == 4'hf);
      if (dly < int'(T)) begin
        n = dly + 1; e.rd = 32'hC0DE_0000 + 32'(slot); e.err = 1'b0;
      end else begin
        n = int'(T);
      end
    end
    for (int k = 0; k < n; k++) exp_q.push_back(e);
    e.acc = 1'b0; e.dwe = '0; e.sel = '0; e.we = 1'b0; e.ack = 1'b1;
    exp_q.push_back(e);
  endtask

  // Compare process: every cycle, DUT outputs against the model timeline (idle when empty).
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset_n) begin
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (e.ack) begin m_rd = e.rd; m_err = e.err; end
      chk("mon_ack", 32'(cpu_ack), 32'(e.ack));
      chk("mon_dm_we", 32'(dm_we), 32'(e.dwe));
      chk("mon_slv_sel", 32'(slv_sel), 32'(e.sel));
      chk("mon_slv_we", 32'(slv_we), 32'(e.we));
      chk("mon_cpu_rd", cpu_rd, m_rd);
      chk("mon_cpu_err", 32'(cpu_err), 32'(m_err));
      if (e.acc) begin
        chk("mon_dm_addr", dm_addr, e.addr);
        chk("mon_slv_addr", slv_addr, e.addr);
        chk("mon_slv_wd", slv_wd, e.wd);
        chk("mon_dm_wd", dm_wd, e.wd);
      end
    end
  end

  // Issue one access and measure req-to-ack latency and strobe activity.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input int dly, output int lat, output int strb, output int wecyc);
    @(negedge clk); #1;
    ready_dly = dly;
    cpu_addr = a; cpu_wd = wd; cpu_byteen = be; cpu_req = 1'b1;
    predict(a, wd, be, dly);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = 0; strb = 0; wecyc = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (dm_we != 4'h0 || slv_sel != '0 || slv_we) strb++;
      if (slv_we) wecyc++;
      if (cpu_ack) break;
      if (lat > 300) begin
        chk("ack_timeout", 32'(lat), 32'd0);
        break;
      end
    end
  endtask

  int lat, strb, wecyc, nack;

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wd = '0; cpu_byteen = '0;
    dm_rd = '0; irq_in = '0; slv_ready = '0;
    slv_rd = {32'hC0DE_0001, 32'hC0DE_0000};
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_rd", cpu_rd, 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_irq", 32'(irq_out), 32'd0);
    chk("rst_sel", 32'(slv_sel), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    #1 reset_n = 1'b1;
    mon_en = 1;

    // DM read
    dm_rd = 32'hA5A5_0001;
    do_access(32'h100, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("dm_rd_lat", 32'(lat), 32'd2);
    chk("dm_rd_data", cpu_rd, 32'hA5A5_0001);
    chk("dm_rd_err", 32'(cpu_err), 32'd0);
    chk("dm_rd_nostrobe", 32'(strb), 32'd0);

    // DM partial write at top of memory, then boundary read
    dm_rd = 32'h1234_5678;
    do_access(32'h2ffc, 32'hDEAD_BEEF, 4'b0101, 0, lat, strb, wecyc);
    chk("dm_wr_strobe_cycles", 32'(strb), 32'd1);
    chk("dm_wr_err", 32'(cpu_err), 32'd0);
    do_access(32'h2fff, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("dm_end_err", 32'(cpu_err), 32'd0);
    do_access(32'h3000, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("dm_end_plus1_err", 32'(cpu_err), 32'd1);
    chk("dm_end_plus1_rd", cpu_rd, 32'd0);

    // Slot 1 full write, ready after 3 cycles
    do_access(32'h7f14, 32'h0BAD_F00D, 4'hf, 3, lat, strb, wecyc);
    chk("slv_wr_we_cycles", 32'(wecyc), 32'd4);
    chk("slv_wr_lat", 32'(lat), 32'd5);
    chk("slv_wr_err", 32'(cpu_err), 32'd0);

    // Slot 0 last decoded offset, immediate ready; first offset past span
    do_access(32'h7f0b, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("slv0_rd_data", cpu_rd, 32'hC0DE_0000);
    chk("slv0_rd_lat", 32'(lat), 32'd2);
    do_access(32'h7f0c, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("span_edge_err", 32'(cpu_err), 32'd1);

    // Ready on the last allowed cycle, then a timeout
    do_access(32'h7f10, 32'h0, 4'h0, 14, lat, strb, wecyc);
    chk("slv_late_err", 32'(cpu_err), 32'd0);
    chk("slv_late_lat", 32'(lat), 32'd16);
    do_access(32'h7f04, 32'h0, 4'h0, 1000, lat, strb, wecyc);
    chk("timeout_lat", 32'(lat), 32'd16);
    chk("timeout_rd", cpu_rd, 32'd0);
    chk("timeout_err", 32'(cpu_err), 32'd1);

    // Partial slot write, unmapped read
    do_access(32'h7f08, 32'h1111_2222, 4'b0011, 0, lat, strb, wecyc);
    chk("partial_err", 32'(cpu_err), 32'd1);
    chk("partial_nostrobe", 32'(strb), 32'd0);
    do_access(32'h5000, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("unmapped_err", 32'(cpu_err), 32'd1);
    chk("unmapped_nostrobe", 32'(strb), 32'd0);
    chk("unmapped_lat", 32'(lat), 32'd2);

    // Interrupt register
    do_access(IRQA, 32'h1, 4'hf, 0, lat, strb, wecyc);
    @(negedge clk); #1 irq_in = 2'b01;
    repeat (3) @(negedge clk);
`ifdef SYS_BRIDGE_IRQ_EN
    chk("irq_out_on", 32'(irq_out), 32'd1);
`else
    chk("irq_out_tied", 32'(irq_out), 32'd0);
`endif
    do_access(IRQA, 32'h0, 4'h0, 0, lat, strb, wecyc);
`ifdef SYS_BRIDGE_IRQ_EN
    chk("irq_reg_rd", cpu_rd, 32'h0001_0001);
    chk("irq_reg_err", 32'(cpu_err), 32'd0);
    chk("irq_reg_lat", 32'(lat), 32'd2);
`else
    chk("irq_unmapped_err", 32'(cpu_err), 32'd1);
`endif

    // Reset while waiting on a slot
    mon_en = 0;
    @(negedge clk); #1;
    ready_dly = 1000; cpu_addr = 32'h7f04; cpu_byteen = 4'h0; cpu_req = 1'b1;
    @(posedge clk); #1 cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_sel", 32'(slv_sel), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(slv_sel), 32'd0);
    chk("mid_rst_ack", 32'(cpu_ack), 32'd0);
    chk("mid_rst_rd", cpu_rd, 32'd0);
    chk("mid_rst_irq", 32'(irq_out), 32'd0);
    nack = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) nack++;
    end
    chk("rst_no_ack", 32'(nack), 32'd0);
    #1 reset_n = 1'b1;
    exp_q.delete();
    m_rd = '0; m_err = 1'b0; m_mask = '0;
    mon_en = 1;
    dm_rd = 32'h0F0F_F0F0;
    do_access(32'h104, 32'h0, 4'h0, 0, lat, strb, wecyc);
    chk("post_rst_rd", cpu_rd, 32'h0F0F_F0F0);
    chk("post_rst_lat", 32'(lat), 32'd2);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
